// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control: forwarding selects and divider states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_ctrl_pkg;

   // E-stage operand source selects
   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   // Divider sequencer states
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;

   // Register match that never fires on $zero, which is hardwired and never written.
   function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Divider sequencer: IDLE -> BUSY for DIV_CYCLES cycles -> DONE (one-cycle ready pulse) -> IDLE.
// Latency: div_busy high for exactly DIV_CYCLES cycles after the edge seeing divstartE in IDLE.
// Backpressure: divstartE is ignored outside IDLE; the same div stays in E until DONE.
module div_seq
   import mips_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic divstartE,
   output logic div_busy,
   output logic div_ready
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // State and down-counter registers; reset aborts any divide in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= DIV_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, counter update and status decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      div_busy  = 1'b0;
      div_ready = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (divstartE) begin
               state_nxt = DIV_BUSY;
               cnt_nxt   = CNT_LOAD;
            end
         end
         DIV_BUSY: begin
            div_busy = 1'b1;
            if (cnt == '0) state_nxt = DIV_DONE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         DIV_DONE: begin
            div_ready = 1'b1;
            state_nxt = DIV_IDLE;
         end
         default: state_nxt = DIV_IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage MIPS pipe: stalls, flushes, forwarding, divider freeze.
// Latency: hazard outputs are combinational; divider stall lasts DIV_CYCLES cycles.
// Backpressure: stallF/stallD/stallE hold pipeline registers; optional PIPE_PERF_CNT_EN builds stall_cnt.
module hazard_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic [4:0]  rsE,
   input  logic [4:0]  rtE,
   input  logic [4:0]  writeregE,
   input  logic [4:0]  writeregM,
   input  logic [4:0]  writeregW,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemtoRegE,
   input  logic        MemtoRegM,
   input  logic        branchD,
   input  logic        jrD,
   input  logic        divstartE,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        flushE,
   output logic [1:0]  forwardAE,
   output logic [1:0]  forwardBE,
   output logic        forwardAD,
   output logic        forwardBD,
   output logic        div_busy,
   output logic        div_ready,
   output logic [31:0] stall_cnt
);

   logic lwstall, brstall, divstall;

   div_seq #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div_seq (
      .clk       (clk),
      .reset     (reset),
      .divstartE (divstartE),
      .div_busy  (div_busy),
      .div_ready (div_ready)
   );

   // Hazard detection and forwarding; M beats W because it holds the younger result.
   always_comb begin
      forwardAE = FWD_NONE;
      forwardBE = FWD_NONE;
      if (RegWriteM && reg_hit(rsE, writeregM))      forwardAE = FWD_MEM;
      else if (RegWriteW && reg_hit(rsE, writeregW)) forwardAE = FWD_WB;
      if (RegWriteM && reg_hit(rtE, writeregM))      forwardBE = FWD_MEM;
      else if (RegWriteW && reg_hit(rtE, writeregW)) forwardBE = FWD_WB;

      forwardAD = RegWriteM && reg_hit(rsD, writeregM);
      forwardBD = RegWriteM && reg_hit(rtD, writeregM);

      lwstall  = MemtoRegE && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE));
      brstall  = (branchD || jrD) &&
                 ((RegWriteE && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE))) ||
                  (MemtoRegM && (reg_hit(rsD, writeregM) || reg_hit(rtD, writeregM))));
      divstall = div_busy;

      stallF = lwstall || brstall || divstall;
      stallD = stallF;
      stallE = divstall;
      // The div must stay in E while it runs, so a bubble is never inserted then.
      flushE = (lwstall || brstall) && !divstall;
   end

`ifdef PIPE_PERF_CNT_EN
   // Count decode-stall cycles; wraps at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt <= 32'd0;
      else if (stallD) stall_cnt <= stall_cnt + 32'd1;
   end
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational hazard vectors plus divider sequences.
// Runs the DUT with DIV_CYCLES=4; stall_cnt expectation follows PIPE_PERF_CNT_EN.
// Ends with one summary line.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic        branchD, jrD, divstartE;
   logic        stallF, stallD, stallE, flushE;
   logic [1:0]  forwardAE, forwardBE;
   logic        forwardAD, forwardBD, div_busy, div_ready;
   logic [31:0] stall_cnt;

   int nvec = 0;
   int nerr = 0;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [31:0] EXP_DIV_STALLS = 32'd4;
`else
   localparam logic [31:0] EXP_DIV_STALLS = 32'd0;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .branchD(branchD), .jrD(jrD), .divstartE(divstartE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .div_busy(div_busy), .div_ready(div_ready), .stall_cnt(stall_cnt)
   );

   typedef struct {
      string      name;
      logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
      logic       rwE, rwM, rwW, m2rE, m2rM, br, jr;
      logic [9:0] exp;   // {stallF,stallD,stallE,flushE,forwardAE,forwardBE,forwardAD,forwardBD}
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
      writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemtoRegM = 1'b0;
      branchD = 1'b0; jrD = 1'b0;
   endtask

   function automatic logic [9:0] outs();
      return {stallF, stallD, stallE, flushE, forwardAE, forwardBE, forwardAD, forwardBD};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           name        rsD   rtD   rsE   rtE   wE    wM    wW   rwE  rwM  rwW  m2rE m2rM br   jr   exp
      vecs.push_back('{"idle",  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'b0000_00_00_00});
      vecs.push_back('{"lw_rs", 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 10'b1101_00_00_00});
      vecs.push_back('{"lw_rt", 5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 10'b1101_00_00_00});
      vecs.push_back('{"lw_r0", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 10'b0000_00_00_00});
      vecs.push_back('{"fw_mw", 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 10'b0000_10_00_00});
      vecs.push_back('{"fw_w",  5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'b0000_01_00_00});
      vecs.push_back('{"fw_r0", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 10'b0000_00_00_00});
      vecs.push_back('{"fwB_w", 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'b0000_00_01_00});
      vecs.push_back('{"fwB_m", 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 5'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 10'b0000_00_10_00});
      vecs.push_back('{"br_E",  5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 10'b1101_00_00_00});
      vecs.push_back('{"br_M",  5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 10'b0000_00_00_01});
      vecs.push_back('{"jr_ldM",5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 10'b1101_00_00_10});
      vecs.push_back('{"nobr",  5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'b0000_00_00_00});
      vecs.push_back('{"fAD",   5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 10'b0000_00_00_10});

      // Reset state
      clear_inputs();
      divstartE = 1'b0;
      reset = 1'b0;
      #12;
      chk("rst_busy",  32'(div_busy),  32'd0);
      chk("rst_ready", 32'(div_ready), 32'd0);
      chk("rst_cnt",   stall_cnt,      32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Combinational hazard table
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rsD = vecs[i].rsD; rtD = vecs[i].rtD; rsE = vecs[i].rsE; rtE = vecs[i].rtE;
         writeregE = vecs[i].wE; writeregM = vecs[i].wM; writeregW = vecs[i].wW;
         RegWriteE = vecs[i].rwE; RegWriteM = vecs[i].rwM; RegWriteW = vecs[i].rwW;
         MemtoRegE = vecs[i].m2rE; MemtoRegM = vecs[i].m2rM;
         branchD = vecs[i].br; jrD = vecs[i].jr;
         #1;
         chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      end

      // Divide with a load-use hazard overlaid: E must hold, never flush
      @(negedge clk);
      clear_inputs();
      MemtoRegE = 1'b1; writeregE = 5'd5; rsD = 5'd5;
      divstartE = 1'b1;
      #1;
      chk("div_pre_stallE", 32'(stallE), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("div_busy%0d", k), 32'({stallF, stallD, stallE, flushE, div_busy, div_ready}), 32'b111010);
      end
      clear_inputs();
      @(posedge clk); #1;
      chk("div_done", 32'({stallF, stallD, stallE, div_busy, div_ready}), 32'b00001);
      divstartE = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("div_idle%0d", k), 32'({stallE, div_busy, div_ready}), 32'b000);
      end

      // Reset during the second BUSY cycle, then a full divide from reset
      @(negedge clk);
      divstartE = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_pre_busy", 32'(div_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_busy",  32'({div_busy, stallE, div_ready}), 32'b000);
      chk("abort_cnt",   stall_cnt, 32'd0);
      @(posedge clk); #1;
      chk("abort_held", 32'({div_busy, div_ready}), 32'b00);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("restart_busy%0d", k), 32'({stallF, stallD, stallE, flushE, div_busy, div_ready}), 32'b111010);
      end
      @(posedge clk); #1;
      chk("restart_done", 32'({stallE, div_busy, div_ready}), 32'b001);
      chk("stall_cnt_div", stall_cnt, EXP_DIV_STALLS);
      divstartE = 1'b0;
      @(posedge clk); #1;
      chk("restart_idle", 32'({stallE, div_busy, div_ready}), 32'b000);
      chk("stall_cnt_hold", stall_cnt, EXP_DIV_STALLS);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
